// File: rtl/ucie_ctl_rx_pkg.sv
// Shared state encoding and sizing helpers for the UCIe control-path RX buffer.
package ucie_ctl_rx_pkg;

    localparam int unsigned RX_ST_W = 4;

    // One-hot state codes
    localparam logic [RX_ST_W-1:0] RX_ST_IDLE     = 4'b0001;
    localparam logic [RX_ST_W-1:0] RX_ST_ACTIVE   = 4'b0010;
    localparam logic [RX_ST_W-1:0] RX_ST_DRAIN    = 4'b0100;
    localparam logic [RX_ST_W-1:0] RX_ST_OVERFLOW = 4'b1000;

    typedef enum logic [RX_ST_W-1:0] {
        ST_IDLE     = RX_ST_IDLE,
        ST_ACTIVE   = RX_ST_ACTIVE,
        ST_DRAIN    = RX_ST_DRAIN,
        ST_OVERFLOW = RX_ST_OVERFLOW
    } rx_state_e;

    // Occupancy width: must represent 0..depth inclusive
    function automatic int unsigned fill_w(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

endpackage

// File: rtl/ucie_ctl_rx_fifo.sv
// Power-of-two FWFT storage for the RX buffer; the caller qualifies wr_en/rd_en.
module ucie_ctl_rx_fifo
    import ucie_ctl_rx_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    input  logic                        flush,
    output logic                        full,
    output logic                        empty,
    output logic [fill_w(DEPTH)-1:0]    count,
    output logic [DATA_W-1:0]           head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = fill_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage array; contents are intentionally left unreset
    always_ff @(posedge i_clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; flush discards everything
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/ucie_ctl_rx_buffer_ctrl.sv
// RX buffer controller: link-side capture, FWFT consumer port, drain and overflow flush.
// Optional saturating overflow counter enabled by defining UCIE_CTL_RX_OVF_CNT_EN.
module ucie_ctl_rx_buffer_ctrl
    import ucie_ctl_rx_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_rx_enable,
    input  logic                        i_rx_valid,
    input  logic [DATA_W-1:0]           i_rx_data,
    output logic                        o_rd_valid,
    output logic [DATA_W-1:0]           o_rd_data,
    input  logic                        i_rd_ready,
    output logic                        o_buffer_enable,
    output logic                        o_draining,
    output logic                        o_overflow_detected,
    output logic [fill_w(DEPTH)-1:0]    o_fill_level,
    output logic [CNT_W-1:0]            o_ovf_count
);

    localparam int unsigned CW = fill_w(DEPTH);

    rx_state_e         state;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_after;
    logic [DATA_W-1:0] head;
    logic              rd_valid_c;
    logic              rd_fire;
    logic              wr_en;
    logic              ovf;
    logic              flush;

    // Read/write qualification and the occupancy that will hold after this edge
    always_comb begin
        rd_valid_c = !empty && ((state == ST_ACTIVE) || (state == ST_DRAIN));
        rd_fire    = rd_valid_c && i_rd_ready;
        wr_en      = (state == ST_ACTIVE) && i_rx_valid && (!full || rd_fire);
        ovf        = (state == ST_ACTIVE) && i_rx_valid && full && !rd_fire;
        flush      = (state == ST_OVERFLOW);
        case ({wr_en, rd_fire})
            2'b10:   count_after = count + CW'(1);
            2'b01:   count_after = count - CW'(1);
            default: count_after = count;
        endcase
    end

    ucie_ctl_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (wr_en),
        .wr_data (i_rx_data),
        .rd_en   (rd_fire),
        .flush   (flush),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .head    (head)
    );

    // Control FSM; status outputs are registered alongside the state they decode
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state               <= ST_IDLE;
            o_buffer_enable     <= 1'b0;
            o_draining          <= 1'b0;
            o_overflow_detected <= 1'b0;
        end else begin
            o_buffer_enable     <= 1'b0;
            o_draining          <= 1'b0;
            o_overflow_detected <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rx_enable) begin
                        state           <= ST_ACTIVE;
                        o_buffer_enable <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (ovf) begin
                        state               <= ST_OVERFLOW;
                        o_overflow_detected <= 1'b1;
                    end else if (!i_rx_enable) begin
                        if (count_after != '0) begin
                            state      <= ST_DRAIN;
                            o_draining <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        state           <= ST_ACTIVE;
                        o_buffer_enable <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (count_after == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        state      <= ST_DRAIN;
                        o_draining <= 1'b1;
                    end
                end
                ST_OVERFLOW: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Head data is masked when nothing is presentable so it reads 0 out of reset
    assign o_rd_valid   = rd_valid_c;
    assign o_rd_data    = rd_valid_c ? head : '0;
    assign o_fill_level = count;

`ifdef UCIE_CTL_RX_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_cnt;

    // Saturating count of overflow events, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ovf_cnt <= '0;
        end else if (ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

    assign o_ovf_count = ovf_cnt;
`else
    assign o_ovf_count = '0;
`endif

endmodule

// File: tb/tb_ucie_ctl_rx_buffer_ctrl.sv
// Directed bench for ucie_ctl_rx_buffer_ctrl (DATA_W=32, DEPTH=8, CNT_W=2).
module tb_ucie_ctl_rx_buffer_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = 2;

    logic              i_clk;
    logic              i_rst;
    logic              i_rx_enable;
    logic              i_rx_valid;
    logic [DATA_W-1:0] i_rx_data;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;
    logic              i_rd_ready;
    logic              o_buffer_enable;
    logic              o_draining;
    logic              o_overflow_detected;
    logic [3:0]        o_fill_level;
    logic [CNT_W-1:0]  o_ovf_count;

    int n_cmp;
    int n_err;

    ucie_ctl_rx_buffer_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_rx_enable         (i_rx_enable),
        .i_rx_valid          (i_rx_valid),
        .i_rx_data           (i_rx_data),
        .o_rd_valid          (o_rd_valid),
        .o_rd_data           (o_rd_data),
        .i_rd_ready          (i_rd_ready),
        .o_buffer_enable     (o_buffer_enable),
        .o_draining          (o_draining),
        .o_overflow_detected (o_overflow_detected),
        .o_fill_level        (o_fill_level),
        .o_ovf_count         (o_ovf_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one cycle; outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] exp_ovf(input int k);
`ifdef UCIE_CTL_RX_OVF_CNT_EN
        return (k > 3) ? 2'd3 : CNT_W'(k);
`else
        return (k > 0) ? 2'd0 : 2'd0;
`endif
    endfunction

    task automatic test_reset();
        i_rst = 1'b0; i_rx_enable = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0; i_rd_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %0b want 0", o_rd_valid); end
        n_cmp++; if (o_rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", o_rd_data); end
        n_cmp++; if (o_buffer_enable !== 1'b0) begin n_err++; $display("FAIL reset_buf_en got %0b want 0", o_buffer_enable); end
        n_cmp++; if (o_draining !== 1'b0) begin n_err++; $display("FAIL reset_draining got %0b want 0", o_draining); end
        n_cmp++; if (o_overflow_detected !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", o_overflow_detected); end
        n_cmp++; if (o_fill_level !== 4'd0) begin n_err++; $display("FAIL reset_fill got %0d want 0", o_fill_level); end
        n_cmp++; if (o_ovf_count !== 2'd0) begin n_err++; $display("FAIL reset_ovf_cnt got %0d want 0", o_ovf_count); end
        i_rst = 1'b1;
        tick();
        n_cmp++; if (o_buffer_enable !== 1'b0) begin n_err++; $display("FAIL idle_hold_buf_en got %0b want 0", o_buffer_enable); end
    endtask

    task automatic test_basic_rw();
        logic [DATA_W-1:0] exp_w [3];
        exp_w[0] = 32'hAAAA_0001; exp_w[1] = 32'hBBBB_0002; exp_w[2] = 32'hCCCC_0003;
        i_rx_enable = 1'b1;
        tick();
        n_cmp++; if (o_buffer_enable !== 1'b1) begin n_err++; $display("FAIL basic_enable got %0b want 1", o_buffer_enable); end
        for (int i = 0; i < 3; i++) begin
            i_rx_valid = 1'b1; i_rx_data = exp_w[i];
            tick();
        end
        i_rx_valid = 1'b0;
        n_cmp++; if (o_fill_level !== 4'd3) begin n_err++; $display("FAIL basic_fill3 got %0d want 3", o_fill_level); end
        n_cmp++; if (o_rd_valid !== 1'b1) begin n_err++; $display("FAIL basic_rd_valid got %0b want 1", o_rd_valid); end
        i_rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (o_rd_data !== exp_w[i]) begin n_err++; $display("FAIL basic_head%0d got %h want %h", i, o_rd_data, exp_w[i]); end
            tick();
        end
        i_rd_ready = 1'b0;
        n_cmp++; if (o_fill_level !== 4'd0) begin n_err++; $display("FAIL basic_fill0 got %0d want 0", o_fill_level); end
        n_cmp++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty_valid got %0b want 0", o_rd_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            i_rx_valid = 1'b1; i_rx_data = 32'hD000_0000 + 32'(i);
            tick();
        end
        n_cmp++; if (o_fill_level !== 4'd8) begin n_err++; $display("FAIL ovf_fill8 got %0d want 8", o_fill_level); end
        n_cmp++; if (o_overflow_detected !== 1'b0) begin n_err++; $display("FAIL ovf_early got %0b want 0", o_overflow_detected); end
        i_rx_data = 32'hDEAD_0009;
        tick();
        i_rx_valid = 1'b0;
        n_cmp++; if (o_overflow_detected !== 1'b1) begin n_err++; $display("FAIL ovf_pulse got %0b want 1", o_overflow_detected); end
        n_cmp++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL ovf_rd_valid got %0b want 0", o_rd_valid); end
        n_cmp++; if (o_buffer_enable !== 1'b0) begin n_err++; $display("FAIL ovf_buf_en got %0b want 0", o_buffer_enable); end
        n_cmp++; if (o_ovf_count !== exp_ovf(1)) begin n_err++; $display("FAIL ovf_count1 got %0d want %0d", o_ovf_count, exp_ovf(1)); end
        tick();
        n_cmp++; if (o_overflow_detected !== 1'b0) begin n_err++; $display("FAIL ovf_one_cycle got %0b want 0", o_overflow_detected); end
        n_cmp++; if (o_fill_level !== 4'd0) begin n_err++; $display("FAIL ovf_flushed got %0d want 0", o_fill_level); end
        n_cmp++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL ovf_idle_valid got %0b want 0", o_rd_valid); end
        n_cmp++; if (o_buffer_enable !== 1'b0) begin n_err++; $display("FAIL ovf_idle_buf_en got %0b want 0", o_buffer_enable); end
        tick();
        n_cmp++; if (o_buffer_enable !== 1'b1) begin n_err++; $display("FAIL ovf_reenable got %0b want 1", o_buffer_enable); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) begin
            i_rx_valid = 1'b1; i_rx_data = 32'hE000_0000 + 32'(i);
            tick();
        end
        i_rx_data = 32'hE000_0008; i_rd_ready = 1'b1;
        n_cmp++; if (o_rd_data !== 32'hE000_0000) begin n_err++; $display("FAIL full_head0 got %h want e0000000", o_rd_data); end
        tick();
        i_rx_valid = 1'b0;
        n_cmp++; if (o_overflow_detected !== 1'b0) begin n_err++; $display("FAIL full_no_ovf got %0b want 0", o_overflow_detected); end
        n_cmp++; if (o_fill_level !== 4'd8) begin n_err++; $display("FAIL full_count8 got %0d want 8", o_fill_level); end
        n_cmp++; if (o_buffer_enable !== 1'b1) begin n_err++; $display("FAIL full_still_active got %0b want 1", o_buffer_enable); end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (o_rd_data !== 32'hE000_0000 + 32'(i)) begin n_err++; $display("FAIL full_head%0d got %h want %h", i, o_rd_data, 32'hE000_0000 + 32'(i)); end
            tick();
        end
        i_rd_ready = 1'b0;
        n_cmp++; if (o_fill_level !== 4'd0) begin n_err++; $display("FAIL full_drained got %0d want 0", o_fill_level); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 2; i++) begin
            i_rx_valid = 1'b1; i_rx_data = 32'hF000_0000 + 32'(i);
            tick();
        end
        i_rx_valid = 1'b0; i_rx_enable = 1'b0;
        tick();
        n_cmp++; if (o_draining !== 1'b1) begin n_err++; $display("FAIL drain_enter got %0b want 1", o_draining); end
        n_cmp++; if (o_buffer_enable !== 1'b0) begin n_err++; $display("FAIL drain_buf_en got %0b want 0", o_buffer_enable); end
        n_cmp++; if (o_rd_data !== 32'hF000_0000) begin n_err++; $display("FAIL drain_head0 got %h want f0000000", o_rd_data); end
        i_rx_valid = 1'b1; i_rx_data = 32'h5555_5555; i_rx_enable = 1'b1; i_rd_ready = 1'b1;
        tick();
        n_cmp++; if (o_draining !== 1'b1) begin n_err++; $display("FAIL drain_hold got %0b want 1", o_draining); end
        n_cmp++; if (o_fill_level !== 4'd1) begin n_err++; $display("FAIL drain_fill1 got %0d want 1", o_fill_level); end
        n_cmp++; if (o_rd_data !== 32'hF000_0001) begin n_err++; $display("FAIL drain_head1 got %h want f0000001", o_rd_data); end
        tick();
        n_cmp++; if (o_draining !== 1'b0) begin n_err++; $display("FAIL drain_exit got %0b want 0", o_draining); end
        n_cmp++; if (o_buffer_enable !== 1'b0) begin n_err++; $display("FAIL drain_idle got %0b want 0", o_buffer_enable); end
        n_cmp++; if (o_fill_level !== 4'd0) begin n_err++; $display("FAIL drain_fill0 got %0d want 0", o_fill_level); end
        i_rx_valid = 1'b0; i_rd_ready = 1'b0;
        tick();
        n_cmp++; if (o_buffer_enable !== 1'b1) begin n_err++; $display("FAIL drain_reenable got %0b want 1", o_buffer_enable); end
        n_cmp++; if (o_fill_level !== 4'd0) begin n_err++; $display("FAIL drain_dropped got %0d want 0", o_fill_level); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            i_rx_valid = 1'b1; i_rx_data = 32'h7000_0000 + 32'(i);
            tick();
        end
        i_rx_valid = 1'b0;
        n_cmp++; if (o_fill_level !== 4'd5) begin n_err++; $display("FAIL arst_fill5 got %0d want 5", o_fill_level); end
        #3;
        i_rst = 1'b0; i_rx_enable = 1'b0;
        #1;
        n_cmp++; if (o_fill_level !== 4'd0) begin n_err++; $display("FAIL arst_fill got %0d want 0", o_fill_level); end
        n_cmp++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL arst_rd_valid got %0b want 0", o_rd_valid); end
        n_cmp++; if (o_rd_data !== 32'h0) begin n_err++; $display("FAIL arst_rd_data got %h want 0", o_rd_data); end
        n_cmp++; if (o_buffer_enable !== 1'b0) begin n_err++; $display("FAIL arst_buf_en got %0b want 0", o_buffer_enable); end
        tick();
        i_rst = 1'b1;
        tick();
        n_cmp++; if (o_buffer_enable !== 1'b0) begin n_err++; $display("FAIL arst_idle got %0b want 0", o_buffer_enable); end
        n_cmp++; if (o_fill_level !== 4'd0) begin n_err++; $display("FAIL arst_post_fill got %0d want 0", o_fill_level); end
        n_cmp++; if (o_ovf_count !== 2'd0) begin n_err++; $display("FAIL arst_ovf_cnt got %0d want 0", o_ovf_count); end
    endtask

    task automatic test_ovf_count();
        i_rx_enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            for (int i = 0; i < 9; i++) begin
                i_rx_valid = 1'b1; i_rx_data = 32'h9000_0000 + 32'(i);
                tick();
            end
            i_rx_valid = 1'b0;
            n_cmp++; if (o_overflow_detected !== 1'b1) begin n_err++; $display("FAIL ovfc_pulse%0d got %0b want 1", k, o_overflow_detected); end
            n_cmp++; if (o_ovf_count !== exp_ovf(k)) begin n_err++; $display("FAIL ovfc_count%0d got %0d want %0d", k, o_ovf_count, exp_ovf(k)); end
            tick();
        end
        i_rx_enable = 1'b0;
        tick();
        n_cmp++; if (o_ovf_count !== exp_ovf(4)) begin n_err++; $display("FAIL ovfc_hold got %0d want %0d", o_ovf_count, exp_ovf(4)); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic_rw();
        test_overflow();
        test_full_rw();
        test_drain();
        test_async_reset();
        test_ovf_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
